// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller.
// Optional round-robin arbitration is selected with IRQ_ROTATE_PRIORITY_EN.
package interrupt_controller_pkg;

  localparam int unsigned CauseW       = 4;
  localparam logic [31:0] DefNmiVec    = 32'h0000_0100;
  localparam logic [31:0] DefVecBase   = 32'h0000_0180;
  localparam int unsigned DefVecStride = 8;

  localparam logic InaMaskable = 1'b1;
  localparam logic InaNmi      = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSvcInt,
    StSvcNmi,
    StSvcNmiNest
  } state_e;

  function automatic logic [31:0] irq_vector(input logic [31:0] base, input logic [31:0] stride,
                                             input logic [CauseW-1:0] idx);
    return base + stride * 32'(idx);
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational maskable-line arbiter: one-hot grant plus index.
// Fixed lowest-index priority, or round-robin when IRQ_ROTATE_PRIORITY_EN is defined.
module irq_arbiter
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
`ifdef IRQ_ROTATE_PRIORITY_EN
  input  logic [CauseW-1:0]  i_last,
`endif
  output logic [NUM_IRQ-1:0] o_grant,
  output logic [CauseW-1:0]  o_idx,
  output logic               o_valid
);

`ifdef IRQ_ROTATE_PRIORITY_EN
  // Pick the requester with the smallest circular distance after the last grant.
  always_comb begin
    int best;
    o_grant = '0;
    o_idx   = '0;
    best    = int'(NUM_IRQ);
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      int dist;
      dist = (i + 2 * int'(NUM_IRQ) - 1 - int'(i_last)) % int'(NUM_IRQ);
      if (i_req[i] && dist < best) begin
        best       = dist;
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = CauseW'(i);
      end
    end
    o_valid = (best < int'(NUM_IRQ));
  end
`else
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (i_req[i] && !o_valid) begin
        o_valid    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = CauseW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching interrupt controller with NMI, one level of NMI nesting over a maskable handler.
// Define IRQ_ROTATE_PRIORITY_EN for round-robin maskable arbitration.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] NMI_VEC    = DefNmiVec,
  parameter logic [31:0] VEC_BASE   = DefVecBase,
  parameter int unsigned VEC_STRIDE = DefVecStride
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] IrqIn,
  input  logic               NMI,
  input  logic               INTD,
  input  logic               MaskWe,
  input  logic [NUM_IRQ-1:0] MaskData,
  input  logic               Boundary,
  input  logic               Ack,
  input  logic               Eret,
  output logic               IntReq,
  output logic               INA,
  output logic [31:0]        IntVector,
  output logic [3:0]         IntCause,
  output logic               InService,
  output logic [NUM_IRQ-1:0] Pending
);

  state_e              r_state, w_state_d;
  logic [NUM_IRQ-1:0]  r_pend, r_prev, r_mask;
  logic                r_nmi_pend, r_nmi_prev;
  logic                r_int_req, r_ina, r_in_svc;
  logic [31:0]         r_vec;
  logic [CauseW-1:0]   r_cause, r_saved_cause;

  logic [NUM_IRQ-1:0]  w_irq_elig, w_grant, w_clr_irq;
  logic [CauseW-1:0]   w_idx, w_saved_cause_d;
  logic                w_irq_valid, w_nmi_elig, w_any, w_take, w_clr_nmi;
  logic                w_int_req_d, w_ina_d, w_in_svc_d;
  logic [31:0]         w_vec_d;
  logic [CauseW-1:0]   w_cause_d;

`ifdef IRQ_ROTATE_PRIORITY_EN
  logic [CauseW-1:0]   r_last;
`endif

  always_comb begin
    w_irq_elig = '0;
    if ((r_state == StIdle || r_state == StReq) && !INTD) w_irq_elig = r_pend & r_mask;
  end

  assign w_nmi_elig = r_nmi_pend & (r_state inside {StIdle, StReq, StSvcInt});
  assign w_any      = w_nmi_elig | w_irq_valid;
  // Eret wins over a coincident Ack.
  assign w_take     = Ack & Boundary & ~Eret & r_int_req;

  irq_arbiter #(
    .NUM_IRQ(NUM_IRQ)
  ) u_arb (
    .i_req  (w_irq_elig),
`ifdef IRQ_ROTATE_PRIORITY_EN
    .i_last (r_last),
`endif
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_valid(w_irq_valid)
  );

  always_comb begin
    w_state_d       = r_state;
    w_clr_irq       = '0;
    w_clr_nmi       = 1'b0;
    w_saved_cause_d = r_saved_cause;
    case (r_state)
      StIdle: if (w_any) w_state_d = StReq;
      StReq: begin
        if (!w_any) begin
          w_state_d = StIdle;
        end else if (w_take) begin
          if (w_nmi_elig) begin
            w_clr_nmi = 1'b1;
            w_state_d = StSvcNmi;
          end else begin
            w_clr_irq       = w_grant;
            w_saved_cause_d = w_idx;
            w_state_d       = StSvcInt;
          end
        end
      end
      StSvcInt: begin
        if (Eret) begin
          w_state_d = StIdle;
        end else if (w_take) begin
          w_clr_nmi = 1'b1;
          w_state_d = StSvcNmiNest;
        end
      end
      StSvcNmi:     if (Eret) w_state_d = StIdle;
      StSvcNmiNest: if (Eret) w_state_d = StSvcInt;
      default:      w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_comb begin
    w_int_req_d = 1'b0;
    w_ina_d     = InaNmi;
    w_vec_d     = '0;
    w_cause_d   = '0;
    w_in_svc_d  = 1'b0;
    case (w_state_d)
      StReq: begin
        w_int_req_d = 1'b1;
        if (w_nmi_elig) begin
          w_vec_d = NMI_VEC;
        end else begin
          w_ina_d   = InaMaskable;
          w_vec_d   = irq_vector(VEC_BASE, 32'(VEC_STRIDE), w_idx);
          w_cause_d = w_idx;
        end
      end
      StSvcInt: begin
        w_in_svc_d = 1'b1;
        if (r_nmi_pend) begin
          w_int_req_d = 1'b1;
          w_vec_d     = NMI_VEC;
        end else begin
          w_ina_d   = InaMaskable;
          w_vec_d   = irq_vector(VEC_BASE, 32'(VEC_STRIDE), w_saved_cause_d);
          w_cause_d = w_saved_cause_d;
        end
      end
      StSvcNmi, StSvcNmiNest: begin
        w_in_svc_d = 1'b1;
        w_vec_d    = NMI_VEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= StIdle;
      r_pend        <= '0;
      r_prev        <= '0;
      r_mask        <= '1;
      r_nmi_pend    <= 1'b0;
      r_nmi_prev    <= 1'b0;
      r_int_req     <= 1'b0;
      r_ina         <= 1'b0;
      r_vec         <= '0;
      r_cause       <= '0;
      r_in_svc      <= 1'b0;
      r_saved_cause <= '0;
    end else begin
      r_state       <= w_state_d;
      // A new edge beats a clear in the same cycle.
      r_pend        <= (r_pend & ~w_clr_irq) | (IrqIn & ~r_prev);
      r_prev        <= IrqIn;
      r_nmi_pend    <= (r_nmi_pend & ~w_clr_nmi) | (NMI & ~r_nmi_prev);
      r_nmi_prev    <= NMI;
      r_mask        <= MaskWe ? MaskData : r_mask;
      r_int_req     <= w_int_req_d;
      r_ina         <= w_ina_d;
      r_vec         <= w_vec_d;
      r_cause       <= w_cause_d;
      r_in_svc      <= w_in_svc_d;
      r_saved_cause <= w_saved_cause_d;
    end
  end

`ifdef IRQ_ROTATE_PRIORITY_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_last <= CauseW'(NUM_IRQ - 1);
    end else if (r_state == StReq && w_state_d == StSvcInt) begin
      r_last <= w_idx;
    end
  end
`endif

  assign IntReq    = r_int_req;
  assign INA       = r_ina;
  assign IntVector = r_vec;
  assign IntCause  = r_cause;
  assign InService = r_in_svc;
  assign Pending   = r_pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: a handler-stack reference model predicts every cycle's outputs.
module tb_interrupt_controller;

  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [N-1:0] IrqIn = '0;
  logic         NMI = 1'b0;
  logic         INTD = 1'b0;
  logic         MaskWe = 1'b0;
  logic [N-1:0] MaskData = '0;
  logic         Boundary = 1'b1;
  logic         Ack = 1'b0;
  logic         Eret = 1'b0;
  logic         IntReq, INA, InService;
  logic [31:0]  IntVector;
  logic [3:0]   IntCause;
  logic [N-1:0] Pending;

  always #5 Clk = ~Clk;

  interrupt_controller dut (
    .Clk(Clk), .Reset(Reset), .IrqIn(IrqIn), .NMI(NMI), .INTD(INTD), .MaskWe(MaskWe),
    .MaskData(MaskData), .Boundary(Boundary), .Ack(Ack), .Eret(Eret), .IntReq(IntReq),
    .INA(INA), .IntVector(IntVector), .IntCause(IntCause), .InService(InService),
    .Pending(Pending)
  );

  typedef struct packed {
    logic         int_req;
    logic         ina;
    logic [31:0]  vec;
    logic [3:0]   cause;
    logic         svc;
    logic [N-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   done = 1'b0;

  // Reference model: pending bits plus a stack of active handlers (-1 = NMI).
  bit       m_pend[N];
  bit       m_prev[N];
  bit       m_nmi, m_nmi_prev;
  bit [N-1:0] m_mask;
  bit       m_req;
  int       m_stack[$];
  int       m_last;
  exp_t     m_out;

  function automatic int pick(bit [N-1:0] elig);
`ifdef IRQ_ROTATE_PRIORITY_EN
    for (int k = 1; k <= N; k++) if (elig[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int i = 0; i < N; i++) if (elig[i]) return i;
`endif
    return -2;
  endfunction

  function automatic logic [31:0] vec_of(int line);
    return (line < 0) ? 32'h100 : 32'h180 + 32'(line) * 32'd8;
  endfunction

  task automatic model_step();
    bit [N-1:0] elig;
    bit nmi_elig, any, take, old_nmi, clr_nmi;
    int win, clr_line;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
      m_nmi = 0; m_nmi_prev = 0; m_mask = '1; m_req = 0; m_stack.delete();
      m_last = N - 1; m_out = '0;
      exp_q.push_back(m_out);
      return;
    end
    elig = '0;
    if (m_stack.size() == 0 && !INTD) for (int i = 0; i < N; i++) elig[i] = m_pend[i] & m_mask[i];
    nmi_elig = m_nmi && (m_stack.size() == 0 || (m_stack.size() == 1 && m_stack[0] >= 0));
    win = nmi_elig ? -1 : pick(elig);
    any = nmi_elig || (elig != '0);
    take = Ack && Boundary && !Eret && m_out.int_req;
    old_nmi = m_nmi; clr_line = -1; clr_nmi = 0;
    if (m_stack.size() == 0) begin
      if (!m_req) m_req = any;
      else if (!any) m_req = 0;
      else if (take) begin
        m_req = 0;
        m_stack.push_back(win);
        if (win < 0) clr_nmi = 1;
        else begin clr_line = win; m_last = win; end
      end
    end else if (Eret) begin
      void'(m_stack.pop_back());
    end else if (take && m_stack.size() == 1 && m_stack[0] >= 0) begin
      m_stack.push_back(-1);
      clr_nmi = 1;
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = (m_pend[i] && i != clr_line) || (IrqIn[i] && !m_prev[i]);
      m_prev[i] = IrqIn[i];
    end
    m_nmi = (m_nmi && !clr_nmi) || (NMI && !m_nmi_prev);
    m_nmi_prev = NMI;
    if (MaskWe) m_mask = MaskData;
    m_out = '0;
    if (m_req) begin
      m_out.int_req = 1;
      m_out.vec = vec_of(win);
      if (win >= 0) begin m_out.ina = 1; m_out.cause = 4'(win); end
    end else if (m_stack.size() > 0) begin
      m_out.svc = 1;
      if (m_stack[$] < 0 || old_nmi) begin
        m_out.int_req = old_nmi && m_stack[$] >= 0;
        m_out.vec = 32'h100;
      end else begin
        m_out.ina = 1; m_out.vec = vec_of(m_stack[$]); m_out.cause = 4'(m_stack[$]);
      end
    end
    for (int i = 0; i < N; i++) m_out.pend[i] = m_pend[i];
    exp_q.push_back(m_out);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_IntReq", 32'(IntReq), 32'(e.int_req));
          chk("sb_INA", 32'(INA), 32'(e.ina));
          chk("sb_IntVector", IntVector, e.vec);
          chk("sb_IntCause", 32'(IntCause), 32'(e.cause));
          chk("sb_InService", 32'(InService), 32'(e.svc));
          chk("sb_Pending", 32'(Pending), 32'(e.pend));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    Reset = 1; IrqIn = '0; NMI = 0; INTD = 0; MaskWe = 0; Ack = 0; Eret = 0; Boundary = 1;
    tick(); tick();
    Reset = 0;
  endtask

  task automatic reach_nest();
    IrqIn = 4'b0001; tick(); tick();
    Ack = 1; tick();
    chk("svc_int_vec", IntVector, 32'h180);
    Ack = 0; NMI = 1; tick(); tick();
    chk("nmi_req", 32'(IntReq), 32'd1);
    chk("nmi_ina", 32'(INA), 32'd0);
    chk("nmi_vec", IntVector, 32'h100);
    Ack = 1; NMI = 0; tick();
    Ack = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_out", {IntReq, INA, InService, IntVector[3:0], IntCause, Pending}, 32'd0);

    IrqIn = 4'b0100; tick();
    chk("pend_t1", 32'(Pending), 32'h4);
    tick();
    chk("req_t2", {IntReq, INA}, 32'h3);
    chk("cause2", 32'(IntCause), 32'd2);
    chk("vec2", IntVector, 32'h190);
    Ack = 1; tick();
    chk("ack_pend", 32'(Pending), 32'd0);
    chk("ack_svc", 32'(InService), 32'd1);
    Ack = 0; Eret = 1; IrqIn = '0; tick();
    chk("eret_idle", {IntReq, InService}, 32'd0);
    Eret = 0;

    do_reset();
    IrqIn = 4'b1010; tick(); tick();
    chk("prio_first", IntVector, 32'h188);
    Ack = 1; tick();
    Ack = 0; Eret = 1; tick();
    Eret = 0; tick();
    chk("prio_second", IntVector, 32'h198);
    Ack = 1; tick();
    Ack = 0; Eret = 1; IrqIn = '0; tick();
    Eret = 0;

    do_reset();
    reach_nest();
    Eret = 1; tick();
    chk("nest_ret_vec", IntVector, 32'h180);
    chk("nest_ret_ina", {INA, InService, IntReq}, 32'h6);
    tick();
    chk("nest_ret_idle", 32'(InService), 32'd0);
    Eret = 0; IrqIn = '0;

    do_reset();
    INTD = 1; IrqIn = 4'b0001; tick();
    IrqIn = '0; tick(); tick();
    chk("intd_noreq", 32'(IntReq), 32'd0);
    chk("intd_pend", 32'(Pending), 32'd1);
    INTD = 0; tick();
    chk("intd_drop_req", 32'(IntReq), 32'd1);
    Ack = 1; tick();
    Ack = 0; Eret = 1; tick();
    Eret = 0; INTD = 1; NMI = 1; tick();
    NMI = 0; tick();
    chk("intd_nmi", {IntReq, INA}, 32'h2);
    INTD = 0;

    do_reset();
    IrqIn = 4'b0100; tick(); tick();
    Ack = 1; Boundary = 0; tick();
    chk("ack_nobnd", {IntReq, InService}, 32'h2);
    Ack = 0; Boundary = 1; MaskWe = 1; MaskData = 4'b1011; tick();
    MaskWe = 0; tick();
    chk("mask_drop", 32'(IntReq), 32'd0);
    chk("mask_pend", 32'(Pending[2]), 32'd1);

    do_reset();
    reach_nest();
    Reset = 1; tick();
    chk("reset_nest", {IntReq, INA, InService, Pending}, 32'd0);
    chk("reset_nest_vec", IntVector, 32'd0);
    Reset = 0; IrqIn = 4'b1000; tick(); tick();
    chk("mask_ones", 32'(IntCause), 32'd3);
    do_reset();

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) IrqIn[i] = ~IrqIn[i];
      if ($urandom_range(0, 39) == 0) NMI = ~NMI;
      if ($urandom_range(0, 59) == 0) INTD = ~INTD;
      MaskWe   = ($urandom_range(0, 49) == 0);
      MaskData = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
      Boundary = ($urandom_range(0, 3) != 0);
      Eret     = (m_stack.size() > 0) && ($urandom_range(0, 5) == 0);
      Ack      = !Eret && (m_out.int_req ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 19) == 0));
      Reset    = ($urandom_range(0, 799) == 0);
      tick();
    end
    Reset = 0; Ack = 0; Eret = 0; MaskWe = 0;
    tick(); tick();
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
